prod_bcd_conv: RTL and testbench

PROD_BCD_CONV -- requirements
Module: prod_bcd_conv

---
 rtl/prod_bcd_conv_pkg.sv | 15 +
 rtl/prod_bcd_conv_digit_adj.sv | 14 +
 rtl/prod_bcd_conv.sv | 124 ++++++++++++
 tb/tb_prod_bcd_conv.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/prod_bcd_conv_pkg.sv
// Shared types and constants for the multiplier-product to packed-BCD converter.
package prod_bcd_conv_pkg;

   localparam int DATA_W = 16;
   localparam int DIGITS = 5;
   localparam int BCD_W  = 4 * DIGITS;

   // 2'b11 is unused and is steered back to ST_IDLE by the FSM.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_HOLD  = 2'b10
   } state_t;

endpackage

// File: rtl/prod_bcd_conv_digit_adj.sv
// One double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_digit_adj (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end
   end

endmodule

// File: rtl/prod_bcd_conv.sv
// Converts a 16-bit multiplier product to packed BCD by 16 double-dabble steps and
// holds the result until acknowledged.
//
// Handshake: done_flag is a one-cycle pulse qualified only in IDLE, or in HOLD together
// with bcd_ack. bcd_valid stays high until the bcd_ack edge. A pulse arriving at any
// other time is discarded and recorded in drop_err.
module prod_bcd_conv
   import prod_bcd_conv_pkg::*;
#(
   parameter int DATA_W = prod_bcd_conv_pkg::DATA_W,
   parameter int DIGITS = prod_bcd_conv_pkg::DIGITS
) (
   input  logic                  clk,
   input  logic                  aclr_n,
   input  logic                  done_flag,
   input  logic [DATA_W-1:0]     product_in,
   input  logic                  bcd_ack,
   output logic                  busy,
   output logic                  bcd_valid,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  drop_err,
   output state_t                state_dbg
);

   localparam int BW = 4 * DIGITS;
   localparam logic [4:0] LAST_STEP = 5'(DATA_W - 1);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   bin_q, bin_d;
   logic [BW-1:0]       acc_q, acc_d;
   logic [4:0]          step_q, step_d;
   logic [BW-1:0]       bcd_out_q, bcd_out_d;
   logic                drop_err_q, drop_err_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic                capture;
   logic [BW-1:0]       adj_acc;
   logic [BW-1:0]       shifted_acc;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (acc_q[4*i +: 4]),
         .digit_o (adj_acc[4*i +: 4])
      );
   end

   // Binary MSB enters the BCD units bit as both halves shift left together.
   assign shifted_acc = {adj_acc[BW-2:0], bin_q[DATA_W-1]};

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      acc_d      = acc_q;
      step_d     = step_q;
      bcd_out_d  = bcd_out_q;
      drop_err_d = drop_err_q;
      capture    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (done_flag) capture = 1'b1;
         end
         ST_SHIFT: begin
            acc_d  = shifted_acc;
            bin_d  = {bin_q[DATA_W-2:0], 1'b0};
            step_d = step_q + 5'd1;
            if (step_q == LAST_STEP) begin
               state_d   = ST_HOLD;
               bcd_out_d = shifted_acc;
            end
            if (done_flag) drop_err_d = 1'b1;
         end
         ST_HOLD: begin
            if (bcd_ack) begin
               state_d = ST_IDLE;
               if (done_flag) capture = 1'b1;
            end else if (done_flag) begin
               drop_err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (capture) begin
         state_d    = ST_SHIFT;
         bin_d      = product_in;
         acc_d      = '0;
         step_d     = '0;
         drop_err_d = 1'b0;
      end

      busy_d  = (state_d == ST_SHIFT);
      valid_d = (state_d == ST_HOLD);
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q    <= ST_IDLE;
         bin_q      <= '0;
         acc_q      <= '0;
         step_q     <= '0;
         bcd_out_q  <= '0;
         drop_err_q <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         acc_q      <= acc_d;
         step_q     <= step_d;
         bcd_out_q  <= bcd_out_d;
         drop_err_q <= drop_err_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
      end
   end

   assign busy      = busy_q;
   assign bcd_valid = valid_q;
   assign bcd_out   = bcd_out_q;
   assign drop_err  = drop_err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Bench for prod_bcd_conv: fixed vector table, corner sequences, and random products
// checked against a decimal-arithmetic reference.
module tb_prod_bcd_conv;
   import prod_bcd_conv_pkg::*;

   logic                clk;
   logic                aclr_n;
   logic                done_flag;
   logic [DATA_W-1:0]   product_in;
   logic                bcd_ack;
   logic                busy;
   logic                bcd_valid;
   logic [BCD_W-1:0]    bcd_out;
   logic                drop_err;
   state_t              state_dbg;

   int n_checks = 0;
   int n_err    = 0;
   logic [BCD_W-1:0] exp_q[$];

   typedef struct {
      logic [DATA_W-1:0] product;
      logic [BCD_W-1:0]  bcd;
   } vec_t;

   vec_t vecs[9];

   prod_bcd_conv u_dut (
      .clk        (clk),
      .aclr_n     (aclr_n),
      .done_flag  (done_flag),
      .product_in (product_in),
      .bcd_ack    (bcd_ack),
      .busy       (busy),
      .bcd_valid  (bcd_valid),
      .bcd_out    (bcd_out),
      .drop_err   (drop_err),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [BCD_W-1:0] bcd_model(input int unsigned v);
      logic [BCD_W-1:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Pulse done_flag for one cycle; returns at the negedge after the capture edge.
   task automatic pulse_done(input logic [DATA_W-1:0] p, input logic ack);
      @(negedge clk);
      done_flag  = 1'b1;
      product_in = p;
      bcd_ack    = ack;
      @(negedge clk);
      done_flag  = 1'b0;
      bcd_ack    = 1'b0;
      product_in = $urandom_range(0, 65535);
   endtask

   // Count busy cycles until HOLD (bounded), watching that bcd_out never moves meanwhile.
   task automatic wait_result(input int already, output int cnt, output bit moved);
      logic [BCD_W-1:0] held;
      held  = bcd_out;
      cnt   = already;
      moved = 1'b0;
      while (busy && cnt < 40) begin
         if (bcd_out !== held) moved = 1'b1;
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic ack_result();
      logic [BCD_W-1:0] held;
      held    = bcd_out;
      bcd_ack = 1'b1;
      @(negedge clk);
      bcd_ack = 1'b0;
      check("ack_valid_low", 32'(bcd_valid), 32'd0);
      check("ack_out_kept", 32'(bcd_out), 32'(held));
   endtask

   task automatic run_conv(input string tag, input logic [DATA_W-1:0] p,
                           input logic [BCD_W-1:0] exp, input logic do_ack);
      int cnt;
      bit moved;
      exp_q.push_back(exp);
      pulse_done(p, 1'b0);
      check({tag, "_drop_clr"}, 32'(drop_err), 32'd0);
      wait_result(0, cnt, moved);
      check({tag, "_busy_cycles"}, 32'(cnt), 32'd16);
      check({tag, "_no_intermediate"}, 32'(moved), 32'd0);
      check({tag, "_valid"}, 32'(bcd_valid), 32'd1);
      check({tag, "_bcd"}, 32'(bcd_out), 32'(exp_q.pop_front()));
      if (do_ack) ack_result();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cnt;
      bit moved;
      bit activity;

      vecs[0] = '{16'h0000, 20'h00000};
      vecs[1] = '{16'hFFFF, 20'h65535};
      vecs[2] = '{16'h3039, 20'h12345};
      vecs[3] = '{16'h2710, 20'h10000};
      vecs[4] = '{16'h0064, 20'h00100};
      vecs[5] = '{16'h00E1, 20'h00225};
      vecs[6] = '{16'h00FF, 20'h00255};
      vecs[7] = '{16'h0009, 20'h00009};
      vecs[8] = '{16'h270F, 20'h09999};

      aclr_n     = 1'b0;
      done_flag  = 1'b0;
      product_in = '0;
      bcd_ack    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(bcd_valid), 32'd0);
      check("rst_bcd", 32'(bcd_out), 32'd0);
      check("rst_drop", 32'(drop_err), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      aclr_n = 1'b1;

      // Ack while idle must be ignored.
      bcd_ack = 1'b1;
      @(negedge clk);
      bcd_ack = 1'b0;
      check("idle_ack_ignored", 32'({busy, bcd_valid}), 32'd0);

      for (int i = 0; i < 9; i++) begin
         run_conv($sformatf("vec%0d", i), vecs[i].product, vecs[i].bcd, 1'b1);
      end

      // Second pulse five cycles into a conversion is dropped.
      exp_q.push_back(20'h00225);
      pulse_done(16'h00E1, 1'b0);
      check("drop_state_shift", 32'(state_dbg), 32'(ST_SHIFT));
      repeat (4) @(negedge clk);
      pulse_done(16'h00FF, 1'b0);
      check("drop_set", 32'(drop_err), 32'd1);
      wait_result(6, cnt, moved);
      check("drop_busy_cycles", 32'(cnt), 32'd16);
      check("drop_bcd", 32'(bcd_out), 32'(exp_q.pop_front()));
      check("drop_sticky_hold", 32'(drop_err), 32'd1);

      // Pulse in HOLD without ack is dropped; the result stays held.
      pulse_done(16'h1234, 1'b0);
      repeat (3) @(negedge clk);
      check("hold_drop_valid", 32'(bcd_valid), 32'd1);
      check("hold_drop_busy", 32'(busy), 32'd0);
      check("hold_drop_bcd", 32'(bcd_out), 32'h00225);

      // Back-to-back: ack and new pulse in the same HOLD cycle.
      exp_q.push_back(20'h10000);
      pulse_done(16'h2710, 1'b1);
      check("b2b_valid_low", 32'(bcd_valid), 32'd0);
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_drop_clr", 32'(drop_err), 32'd0);
      wait_result(0, cnt, moved);
      check("b2b_busy_cycles", 32'(cnt), 32'd16);
      check("b2b_bcd", 32'(bcd_out), 32'(exp_q.pop_front()));
      ack_result();

      // Nothing further should appear after the dropped pulse.
      activity = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (busy || bcd_valid) activity = 1'b1;
      end
      check("no_second_result", 32'(activity), 32'd0);

      // Asynchronous reset mid-conversion with drop_err set.
      pulse_done(16'hFFFF, 1'b0);
      repeat (2) @(negedge clk);
      pulse_done(16'h0001, 1'b0);
      repeat (4) @(negedge clk);
      check("pre_rst_drop", 32'(drop_err), 32'd1);
      #2 aclr_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_valid", 32'(bcd_valid), 32'd0);
      check("arst_bcd", 32'(bcd_out), 32'd0);
      check("arst_drop", 32'(drop_err), 32'd0);
      check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
      @(negedge clk);
      aclr_n     = 1'b1;
      done_flag  = 1'b1;
      product_in = 16'h0064;
      @(negedge clk);
      done_flag = 1'b0;
      check("post_rst_capture", 32'(busy), 32'd1);
      wait_result(0, cnt, moved);
      check("post_rst_cycles", 32'(cnt), 32'd16);
      check("post_rst_bcd", 32'(bcd_out), 32'h00100);
      ack_result();

      // Random products against the decimal model.
      for (int i = 0; i < 30; i++) begin
         logic [DATA_W-1:0] p;
         p = 16'($urandom_range(0, 65535));
         run_conv("rand", p, bcd_model(32'(p)), 1'b1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
